// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register responder.
// Holds the FSM state encoding, command layout and mode decoding.
package spi_pkg;

  localparam int unsigned CMD_DW = 8;
  localparam logic [7:0] STATUS_BYTE_DEF = 8'hA5;
  localparam int unsigned SYNC_STAGES = 2;

  typedef struct packed {
    logic              rw;
    logic [CMD_DW-2:0] addr;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WR,
    RD
  } state_t;

  function automatic logic cpol(input int unsigned mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input int unsigned mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with rise/fall pulses on the synced level.
// Ports: clk_i, arstn_i, d_i in; q_o level, rise_o/fall_o one-clk pulses.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI slave register file: {rw,addr} command byte, then data bytes.
// Ports: clk_i/arstn_i, SPI pins, regs_o, wr_stb/addr/data_o, busy_o.
module spi_reg_responder
  import spi_pkg::*;
#(
  parameter int unsigned SPI_MODE   = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] STATUS_BYTE =
    DATA_WIDTH'(STATUS_BYTE_DEF)
) (
  input  logic                           clk_i,
  input  logic                           arstn_i,
  input  logic                           spi_clk_i,
  input  logic                           spi_cs_i,
  input  logic                           spi_mosi_i,
  output logic                           spi_miso_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic                           wr_stb_o,
  output logic [DATA_WIDTH-2:0]          wr_addr_o,
  output logic [DATA_WIDTH-1:0]          wr_data_o,
  output logic                           busy_o
);

  localparam int unsigned AW = DATA_WIDTH - 1;
  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam int unsigned IW =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic CPOL = cpol(SPI_MODE);
  localparam logic CPHA = cpha(SPI_MODE);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .d_i     (spi_clk_i),
    .q_o     (sclk_s),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .d_i     (spi_cs_i),
    .q_o     (cs_s),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  // MOSI gets the same depth as SCLK so a detected edge sees its bit.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Leading edge leaves CPOL, trailing edge returns to it.
  logic sclk_edge, lead, trail, samp, shft;

  assign sclk_edge = sclk_rise | sclk_fall;
  assign lead      = sclk_edge & (sclk_s != CPOL);
  assign trail     = sclk_edge & (sclk_s == CPOL);
  assign samp      = CPHA ? trail : lead;
  assign shft      = CPHA ? lead : trail;

  state_t                  state_q, state_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-2:0]   rx_q, rx_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d;
  logic                    miso_q, miso_d;
  logic [AW-1:0]           ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  logic                    wr_stb_q, wr_stb_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]   rx_byte;
  logic                    last_bit;

  assign rx_byte  = {rx_q, mosi_s};
  assign last_bit = (bit_cnt_q == LAST);

  function automatic logic [DATA_WIDTH-1:0] rd_data(
    input logic [AW-1:0] a
  );
    if (int'(a) < NUM_REGS) return regs_q[a[IW-1:0]];
    return '0;
  endfunction

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    ptr_d       = ptr_q;
    regs_d      = regs_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    // CS release wins over any SCLK edge in the same cycle.
    if (cs_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      tx_d      = '0;
      miso_d    = 1'b0;
    end else if (state_q == IDLE) begin
      miso_d = 1'b0;
      if (cs_fall) begin
        state_d   = CMD;
        bit_cnt_d = '0;
        // CPHA=0 needs the MSB on the wire before the first edge.
        if (CPHA) begin
          tx_d = STATUS_BYTE;
        end else begin
          tx_d   = STATUS_BYTE << 1;
          miso_d = STATUS_BYTE[DATA_WIDTH-1];
        end
      end
    end else begin
      if (shft) begin
        miso_d = tx_q[DATA_WIDTH-1];
        tx_d   = tx_q << 1;
      end
      if (samp) begin
        rx_d      = rx_byte[DATA_WIDTH-2:0];
        bit_cnt_d = last_bit ? '0 : bit_cnt_q + CW'(1);
        if (last_bit) begin
          unique case (state_q)
            CMD: begin
              ptr_d = rx_byte[AW-1:0];
              if (rx_byte[DATA_WIDTH-1]) begin
                state_d = RD;
                tx_d    = rd_data(rx_byte[AW-1:0]);
              end else begin
                state_d = WR;
                tx_d    = '0;
              end
            end
            WR: begin
              if (int'(ptr_q) < NUM_REGS) begin
                regs_d[ptr_q[IW-1:0]] = rx_byte;
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = rx_byte;
              end
              ptr_d = ptr_q + PTR_ONE;
            end
            RD: begin
              ptr_d = ptr_q + PTR_ONE;
              tx_d  = rd_data(ptr_q + PTR_ONE);
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      ptr_q       <= '0;
      regs_q      <= '{default: '0};
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      ptr_q       <= ptr_d;
      regs_q      <= regs_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_regs
    assign regs_o[n*DATA_WIDTH +: DATA_WIDTH] = regs_q[n];
  end

  assign spi_miso_o = miso_q;
  assign wr_stb_o   = wr_stb_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = ~cs_s;

endmodule
